bsearch_engine: RTL and testbench

- Parametrised binary-search engine over an external sorted synchronous-read RAM (ascending, duplicates allowed).
- Supports two modes: exact-match (first occurrence) and lower-bound (first entry >= target).
- Uses a start/done handshake and reports a step count.
- Sits between the board top level (switch target, hex display of result) and an M10K RAM.

---
 rtl/bsearch_pkg.sv | 17 +
 rtl/bsearch_engine.sv | 130 +++++++++++++
 tb/tb_bsearch_engine.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/bsearch_pkg.sv
// Shared types for the binary-search engine: FSM states, search modes and a
// depth helper used for worst-case latency bounds.
package bsearch_pkg;

  typedef enum logic [2:0] {IDLE, CHECK, READ, VREAD, DONE} state_t;

  typedef enum logic {MODE_EXACT = 1'b0, MODE_LBOUND = 1'b1} mode_t;

  // ceil(log2(depth+1)): halving iterations needed to collapse [0, depth)
  function automatic int clog2_depth(input int depth);
    int r;
    r = 0;
    while ((1 << r) < depth + 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/bsearch_engine.sv
// Binary search over an external sorted sync-read RAM; converges on the lowest
// index whose value is >= target, then verifies it for exact-match mode.
module bsearch_engine
  import bsearch_pkg::*;
#(
  parameter int VAL_WIDTH  = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int STEP_WIDTH = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  mode,
  input  logic [VAL_WIDTH-1:0]  target,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd,
  input  logic [VAL_WIDTH-1:0]  mem_rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  found,
  output logic                  not_found,
  output logic [ADDR_WIDTH-1:0] result_addr,
  output logic                  past_end,
  output logic [STEP_WIDTH-1:0] steps,
  output logic                  hex_en
);

  localparam logic [ADDR_WIDTH:0] DEPTH_V = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_t                state, state_nxt;
  mode_t                 mode_q;
  logic [VAL_WIDTH-1:0]  tgt_q;
  logic [ADDR_WIDTH:0]   lo, hi, mid;
  logic                  found_q, nf_q;

  // lo/hi carry one extra bit so the empty range at DEPTH is representable
  assign mid = lo + ((hi - lo) >> 1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (start) state_nxt = CHECK;
      CHECK: begin
        if (lo < hi)            state_nxt = READ;
        else if (lo == DEPTH_V) state_nxt = DONE;
        else                    state_nxt = VREAD;
      end
      READ:  state_nxt = CHECK;
      VREAD: state_nxt = DONE;
      DONE:  if (!start) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_addr = '0;
    mem_rd   = 1'b0;
    if (state == CHECK) begin
      if (lo < hi) begin
        mem_addr = mid[ADDR_WIDTH-1:0];
        mem_rd   = 1'b1;
      end else if (lo != DEPTH_V) begin
        mem_addr = lo[ADDR_WIDTH-1:0];
        mem_rd   = 1'b1;
      end
    end
  end

  assign busy      = (state == CHECK) || (state == READ) || (state == VREAD);
  assign done      = (state == DONE);
  assign hex_en    = done;
  // flags are held after DONE but only presented while done is high
  assign found     = done & found_q;
  assign not_found = done & nf_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mode_q      <= MODE_EXACT;
      tgt_q       <= '0;
      lo          <= '0;
      hi          <= '0;
      steps       <= '0;
      found_q     <= 1'b0;
      nf_q        <= 1'b0;
      past_end    <= 1'b0;
      result_addr <= '0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          mode_q   <= mode_t'(mode);
          tgt_q    <= target;
          lo       <= '0;
          hi       <= DEPTH_V;
          steps    <= '0;
          found_q  <= 1'b0;
          nf_q     <= 1'b0;
          past_end <= 1'b0;
        end
        CHECK: if (lo == hi && lo == DEPTH_V) begin
          result_addr <= '0;
          past_end    <= 1'b1;
          nf_q        <= 1'b1;
        end
        READ: begin
          steps <= steps + STEP_WIDTH'(1);
          if (mem_rdata < tgt_q) lo <= mid + (ADDR_WIDTH+1)'(1);
          else                   hi <= mid;
        end
        VREAD: begin
          steps       <= steps + STEP_WIDTH'(1);
          result_addr <= lo[ADDR_WIDTH-1:0];
          if (mode_q == MODE_EXACT) begin
            found_q <= (mem_rdata == tgt_q);
            nf_q    <= (mem_rdata != tgt_q);
          end else begin
            found_q <= 1'b1;
            nf_q    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bsearch_engine.sv
// Directed bench for bsearch_engine with a 1-cycle-latency behavioural RAM.
module tb_bsearch_engine;

  localparam int VW = 8;
  localparam int AW = 5;
  localparam int SW = 4;
  localparam int DEPTH = 1 << AW;
  localparam int LAT_MAX = 2 * bsearch_pkg::clog2_depth(DEPTH) + 3;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          mode = 1'b0;
  logic [VW-1:0] target = '0;
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic [VW-1:0] mem_rdata = '0;
  logic          busy, done, found, not_found, past_end, hex_en;
  logic [AW-1:0] result_addr;
  logic [SW-1:0] steps;

  logic [VW-1:0] ram [DEPTH];
  int            rd_cnt = 0;
  int            n_cmp = 0;
  int            n_err = 0;

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mem_rd) begin
      mem_rdata <= ram[mem_addr];
      rd_cnt    <= rd_cnt + 1;
    end
  end

  bsearch_engine #(.VAL_WIDTH(VW), .ADDR_WIDTH(AW), .STEP_WIDTH(SW)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .mode(mode),
    .target(target), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_rdata(mem_rdata), .busy(busy), .done(done), .found(found),
    .not_found(not_found), .result_addr(result_addr), .past_end(past_end),
    .steps(steps), .hex_en(hex_en)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // waits for the accept edge, then up to 40 cycles for done
  task automatic wait_done(output int cyc);
    cyc = 0;
    @(posedge clock);
    @(negedge clock);
    cyc = 1;
    chk("busy_after_accept", busy, 1);
    chk("done_low_after_accept", done, 0);
    while (!done && cyc < 40) begin
      @(negedge clock);
      cyc++;
    end
    chk("done_reached", done, 1);
  endtask

  task automatic search(input logic m, input logic [VW-1:0] t, output int cyc, output int reads);
    int r0;
    @(negedge clock);
    start  = 1'b1;
    mode   = m;
    target = t;
    r0     = rd_cnt;
    wait_done(cyc);
    reads = rd_cnt - r0;
  endtask

  task automatic release_start();
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    chk("done_cleared", done, 0);
    chk("flags_cleared", {found, not_found}, 0);
  endtask

  task automatic expect_res(input string tag, input int f, input int nf,
                            input int addr, input int pe);
    chk({tag, "_found"}, found, f);
    chk({tag, "_not_found"}, not_found, nf);
    chk({tag, "_addr"}, result_addr, addr);
    chk({tag, "_past_end"}, past_end, pe);
    chk({tag, "_hex_en"}, hex_en, 1);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    int cyc, reads;
    for (int i = 0; i < DEPTH; i++) ram[i] = VW'(2 * i + 1);

    repeat (3) @(negedge clock);
    chk("rst_flags", {busy, done, found, not_found, mem_rd, past_end, hex_en}, 0);
    chk("rst_addr", result_addr, 0);
    chk("rst_steps", steps, 0);
    chk("rst_mem_addr", mem_addr, 0);
    reset_n = 1'b1;

    // RAM[i] = 2i+1, exact 33 -> index 16
    search(1'b0, 8'd33, cyc, reads);
    expect_res("ex33", 1, 0, 16, 0);
    chk("ex33_steps", steps, 6);
    chk("ex33_reads", reads, 6);
    chk("ex33_latency_ok", int'(cyc <= LAT_MAX), 1);
    mode = 1'b1; target = 8'd0;
    repeat (3) @(negedge clock);
    chk("hold_done", done, 1);
    chk("hold_addr", result_addr, 16);
    chk("hold_found", found, 1);
    chk("hold_steps", steps, 6);
    release_start();
    chk("idle_addr_held", result_addr, 16);

    search(1'b0, 8'd32, cyc, reads);
    expect_res("ex32", 0, 1, 16, 0);
    release_start();

    search(1'b1, 8'd32, cyc, reads);
    expect_res("lb32", 1, 0, 16, 0);
    release_start();

    search(1'b1, 8'd64, cyc, reads);
    expect_res("lb64", 0, 1, 0, 1);
    chk("lb64_steps", steps, 5);
    chk("lb64_reads", reads, 5);
    release_start();

    search(1'b0, 8'd0, cyc, reads);
    expect_res("ex0", 0, 1, 0, 0);
    chk("ex0_steps", steps, 7);
    chk("ex0_latency_ok", int'(cyc <= LAT_MAX), 1);
    release_start();

    for (int i = 0; i < DEPTH; i++) ram[i] = 8'd7;
    search(1'b0, 8'd7, cyc, reads);
    expect_res("dup7", 1, 0, 0, 0);
    release_start();

    for (int i = 0; i < DEPTH; i++) ram[i] = (i < 16) ? 8'd4 : 8'd9;
    search(1'b0, 8'd9, cyc, reads);
    expect_res("dup9", 1, 0, 16, 0);
    release_start();

    // start pulsed while busy, with mode/target changed, must be ignored
    for (int i = 0; i < DEPTH; i++) ram[i] = VW'(2 * i + 1);
    @(negedge clock);
    start = 1'b1; mode = 1'b0; target = 8'd33;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    start = 1'b1; mode = 1'b1; target = 8'd0;
    @(negedge clock);
    start = 1'b0;
    cyc = 3;
    while (!done && cyc < 40) begin
      @(negedge clock);
      cyc++;
    end
    chk("pulse_done", done, 1);
    chk("pulse_found", found, 1);
    chk("pulse_addr", result_addr, 16);
    chk("pulse_steps", steps, 6);
    @(negedge clock);
    chk("pulse_idle_done", done, 0);
    chk("pulse_idle_addr", result_addr, 16);

    // async reset in the first READ of a target=33 search
    @(negedge clock);
    start = 1'b1; mode = 1'b0; target = 8'd33;
    @(posedge clock);
    @(negedge clock);
    @(negedge clock);
    chk("pre_reset_busy", busy, 1);
    reset_n = 1'b0;
    #1;
    chk("arst_flags", {busy, done, found, not_found, mem_rd, past_end, hex_en}, 0);
    chk("arst_addr", result_addr, 0);
    chk("arst_steps", steps, 0);
    chk("arst_mem_addr", mem_addr, 0);
    @(negedge clock);
    reset_n = 1'b1;
    wait_done(cyc);
    expect_res("post_rst", 1, 0, 16, 0);
    release_start();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
